// File: rtl/pe_ddr_wr_ctrl.sv
// Purpose: buffers a PE result/mask word stream and writes it to DDR as incrementing write bursts from a base address.
// Latency: the first AW is raised at least 1 cycle after the BURST_LEN-th word (or the final word) lands in the FIFO.
// Backpressure: s_ready drops when the FIFO is full; AW waits for a full burst in the FIFO and fewer than MAX_OUTST open bursts.
// Optional: define PE_DDR_WR_PERF_EN to add the perf_stall_cnt output.
module pe_ddr_wr_ctrl #(
  parameter int DW         = 64,
  parameter int AW         = 32,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int MAX_OUTST  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          done,
  input  logic [AW-1:0] conf_base_addr,
  input  logic [15:0]   conf_word_num,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [AW-1:0] m_awaddr,
  output logic [7:0]    m_awlen,
  output logic          m_awvalid,
  input  logic          m_awready,
  output logic [DW-1:0] m_wdata,
  output logic          m_wlast,
  output logic          m_wvalid,
  input  logic          m_wready,
  input  logic          m_bvalid,
  output logic          m_bready
`ifdef PE_DDR_WR_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [15:0]   BL         = 16'(BURST_LEN);
  localparam logic [AW-1:0] WORD_BYTES = AW'(DW / 8);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DATA, S_DRAIN} state_t;
  state_t state, state_nxt;

  logic [AW-1:0] addr;
  logic [15:0]   remaining;
  logic [15:0]   cur_len;
  logic [15:0]   beat;
  logic [15:0]   len_nxt;
  logic [OW-1:0] outst;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic push, pop, aw_hs, w_hs, last_beat, start_ok;

  // Size of the burst about to be issued; constant while in ISSUE so AW stays stable.
  assign len_nxt   = (remaining > BL) ? BL : remaining;

  assign done      = (state == S_IDLE);
  assign s_ready   = (state != S_IDLE) && (count != CW'(FIFO_DEPTH));
  // count only grows and outst only shrinks while in ISSUE, so awvalid never drops before its handshake.
  assign m_awvalid = (state == S_ISSUE) && (16'(count) >= len_nxt) && (outst < OW'(MAX_OUTST));
  assign m_awaddr  = addr;
  assign m_awlen   = 8'(len_nxt - 16'd1);
  // The whole burst is already in the FIFO before AW, so W never runs dry mid-burst.
  assign m_wvalid  = (state == S_DATA);
  assign m_wdata   = mem[rd_ptr];
  assign last_beat = (beat == cur_len - 16'd1);
  assign m_wlast   = m_wvalid && last_beat;
  assign m_bready  = 1'b1;

  assign push     = s_valid && s_ready;
  assign aw_hs    = m_awvalid && m_awready;
  assign w_hs     = m_wvalid && m_wready;
  assign pop      = w_hs;
  assign start_ok = start && done;

  // Next-state: issue, stream one burst, repeat, then wait for all responses.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (conf_word_num == 16'd0) ? S_DRAIN : S_ISSUE;
      S_ISSUE: if (aw_hs) state_nxt = S_DATA;
      S_DATA:  if (w_hs && last_beat) state_nxt = (remaining != 16'd0) ? S_ISSUE : S_DRAIN;
      // A response arriving this cycle for the last open burst lets done rise on the next cycle.
      S_DRAIN: if (outst == '0 || (outst == OW'(1) && m_bvalid)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Job address, words left, current burst length and beat position.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
      cur_len   <= '0;
      beat      <= '0;
    end else begin
      if (start_ok) begin
        addr      <= conf_base_addr;
        remaining <= conf_word_num;
      end else if (aw_hs) begin
        addr      <= addr + AW'(len_nxt) * WORD_BYTES;
        remaining <= remaining - len_nxt;
        cur_len   <= len_nxt;
        beat      <= '0;
      end
      if (w_hs) beat <= last_beat ? 16'd0 : beat + 16'd1;
    end
  end

  // Open-burst count: AW opens, B closes, both together cancel.
  always_ff @(posedge clk) begin
    if (rst)                                     outst <= '0;
    else if (aw_hs && !m_bvalid)                 outst <= outst + OW'(1);
    else if (!aw_hs && m_bvalid && outst != '0)  outst <= outst - OW'(1);
  end

  // FIFO storage; emptied by pointer reset, the array itself needs none.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // FIFO pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef PE_DDR_WR_PERF_EN
  // Busy cycles spent waiting on the DDR side for AW or W acceptance.
  always_ff @(posedge clk) begin
    if (rst)           perf_stall_cnt <= '0;
    else if (start_ok) perf_stall_cnt <= '0;
    else if (!done && ((m_wvalid && !m_wready) || (m_awvalid && !m_awready)))
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_pe_ddr_wr_ctrl.sv
// Bench for pe_ddr_wr_ctrl: table of jobs plus hand-written corner sequences.
// A negedge process plays source and DDR slave and scores every AW/W beat against queues.
// The main process launches jobs, waits for done and checks per-job totals.
`timescale 1ns/1ps
module tb_pe_ddr_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        done;
  logic [31:0] conf_base_addr = '0;
  logic [15:0] conf_word_num = '0;
  logic [63:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic        m_awvalid;
  logic        m_awready = 1'b0;
  logic [63:0] m_wdata;
  logic        m_wlast;
  logic        m_wvalid;
  logic        m_wready = 1'b0;
  logic        m_bvalid = 1'b0;
  logic        m_bready;
`ifdef PE_DDR_WR_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  pe_ddr_wr_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .conf_base_addr(conf_base_addr), .conf_word_num(conf_word_num),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bvalid(m_bvalid), .m_bready(m_bready)
`ifdef PE_DDR_WR_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  typedef struct {
    logic [31:0] base;
    int          n;
    bit          arand;
    bit          wrand;
    bit          gap;
    int          exp_naw;
    int          exp_last_len;
  } vec_t;

  vec_t        vecs[6];
  logic [63:0] src_q[$];
  logic [63:0] exp_w[$];
  aw_t         exp_aw[$];
  int          burst_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rst_cycles = 3;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, b_pending = 0, tb_beat = 0;
  int last_b_cyc = -1, done_rise_cyc = -1, last_len_seen = -1;
  bit aw_rand = 0, w_rand = 0, s_gap = 0, b_hold = 0;
  bit p_aw_stall = 0, p_w_stall = 0, p_done = 1;
  logic [31:0] p_awaddr;
  logic [7:0]  p_awlen;
  logic [63:0] p_wdata;
  logic        p_wlast;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Source, DDR slave and scoreboard, all acting on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_cycles > 0) begin
        rst = 1'b1;
        rst_cycles--;
        s_valid = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        src_q.delete(); exp_w.delete(); exp_aw.delete(); burst_q.delete();
        b_pending = 0; tb_beat = 0;
        p_aw_stall = 0; p_w_stall = 0; p_done = 1;
      end else begin
        rst = 1'b0;
        if (done === 1'b1 && !p_done) done_rise_cyc = cyc;
        p_done = (done === 1'b1);
        if (p_aw_stall) begin
          chk("aw_hold_valid", m_awvalid, 1);
          chk("aw_hold_addr", m_awaddr, p_awaddr);
          chk("aw_hold_len", m_awlen, p_awlen);
        end
        if (p_w_stall) begin
          chk("w_hold_valid", m_wvalid, 1);
          chk("w_hold_data", m_wdata, p_wdata);
          chk("w_hold_last", m_wlast, p_wlast);
        end
        // B for bursts whose last beat completed in an earlier cycle.
        if (b_pending > 0 && !b_hold) begin
          m_bvalid = 1'b1; b_pending--; b_cnt++; last_b_cyc = cyc;
        end else m_bvalid = 1'b0;
        m_awready = aw_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        m_wready  = w_rand  ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_awvalid === 1'b1 && m_awready) begin
          aw_cnt++;
          last_len_seen = int'(m_awlen);
          if (exp_aw.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL aw_unexpected: addr 0x%0h with no burst expected", m_awaddr);
          end else begin
            aw_t e;
            e = exp_aw.pop_front();
            chk("aw_addr", m_awaddr, e.addr);
            chk("aw_len", m_awlen, e.len);
            burst_q.push_back(int'(e.len) + 1);
          end
        end
        if (m_wvalid === 1'b1 && m_wready) begin
          w_cnt++;
          if (burst_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL w_before_aw: beat with no accepted AW, got data 0x%0h", m_wdata);
          end else begin
            if (exp_w.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL w_unexpected: got data 0x%0h with empty scoreboard", m_wdata);
            end else chk("wdata", m_wdata, exp_w.pop_front());
            tb_beat++;
            chk("wlast", m_wlast, (tb_beat == burst_q[0]) ? 1 : 0);
            if (tb_beat == burst_q[0]) begin
              void'(burst_q.pop_front());
              tb_beat = 0;
              b_pending++;
            end
          end
        end
        if (src_q.size() > 0 && (!s_gap || $urandom_range(0, 1) == 1)) begin
          s_valid = 1'b1;
          s_data  = src_q[0];
          if (s_ready === 1'b1) exp_w.push_back(src_q.pop_front());
        end else s_valid = 1'b0;
        p_aw_stall = (m_awvalid === 1'b1) && !m_awready;
        p_awaddr   = m_awaddr;
        p_awlen    = m_awlen;
        p_w_stall  = (m_wvalid === 1'b1) && !m_wready;
        p_wdata    = m_wdata;
        p_wlast    = m_wlast;
      end
    end
  end

  task automatic start_job(input logic [31:0] base, input int n, input bit arand, input bit wrand, input bit gap);
    logic [31:0] a;
    int rem, l;
    aw_rand = arand; w_rand = wrand; s_gap = gap;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    last_b_cyc = -1; last_len_seen = -1;
    a = base; rem = n;
    while (rem > 0) begin
      aw_t e;
      l = (rem > 16) ? 16 : rem;
      e.addr = a; e.len = 8'(l - 1);
      exp_aw.push_back(e);
      a = a + 32'(l * 8);
      rem = rem - l;
    end
    for (int k = 0; k < n; k++) src_q.push_back({$urandom, $urandom});
    conf_base_addr = base;
    conf_word_num  = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_low_after_start", done, 0);
  endtask

  task automatic wait_done(input int bound, input string tag);
    int k;
    k = 0;
    while (done !== 1'b1 && k < bound) begin
      tick();
      k++;
    end
    if (k >= bound) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: done still 0 after %0d cycles", tag, bound);
      rst_cycles = 2;
      repeat (4) tick();
    end
  endtask

  task automatic check_job(input int naw, input int n, input int last_len);
    tick();
    chk("aw_count", aw_cnt, naw);
    chk("w_count", w_cnt, n);
    chk("b_count", b_cnt, naw);
    chk("aw_left", exp_aw.size(), 0);
    chk("w_left", exp_w.size(), 0);
    if (n > 0) begin
      chk("last_awlen", last_len_seen, last_len);
      chk("done_after_last_b", done_rise_cyc, last_b_cyc + 1);
    end
  endtask

  initial begin
    int k;
    vecs[0] = '{32'h1000,  32, 0, 0, 0, 2, 15};
    vecs[1] = '{32'h1000,  20, 0, 0, 0, 2, 3};
    vecs[2] = '{32'h2000, 100, 1, 1, 1, 7, 3};
    vecs[3] = '{32'h0000,  16, 0, 0, 0, 1, 15};
    vecs[4] = '{32'h3000,   1, 1, 0, 1, 1, 0};
    vecs[5] = '{32'h4000,  17, 0, 1, 0, 2, 0};

    repeat (5) tick();
    chk("rst_done", done, 1);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_wlast", m_wlast, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_bready", m_bready, 1);

    for (int i = 0; i < 6; i++) begin
      chk("idle_s_ready", s_ready, 0);
      start_job(vecs[i].base, vecs[i].n, vecs[i].arand, vecs[i].wrand, vecs[i].gap);
      wait_done(3000, "table");
      check_job(vecs[i].exp_naw, vecs[i].n, vecs[i].exp_last_len);
      repeat (2) tick();
    end

    // Empty job: done low for exactly one cycle, no traffic.
    start_job(32'h7000, 0, 0, 0, 0);
    tick();
    chk("zero_done_back", done, 1);
    chk("zero_aw_count", aw_cnt, 0);
    chk("zero_w_count", w_cnt, 0);

    // Withheld responses cap open bursts at 4; a start mid-job is ignored.
    b_hold = 1;
    start_job(32'h5000, 96, 0, 0, 0);
    conf_base_addr = 32'h0dea_d000;
    conf_word_num  = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) tick();
    chk("hold_aw_count", aw_cnt, 4);
    chk("hold_w_count", w_cnt, 64);
    chk("hold_done", done, 0);
    chk("hold_awvalid", m_awvalid, 0);
    b_hold = 0;
    wait_done(2000, "hold");
    check_job(6, 96, 15);

    // Reset in the middle of the second burst's data phase.
    start_job(32'h6000, 32, 0, 0, 0);
    k = 0;
    while (!(aw_cnt == 2 && w_cnt >= 20) && k < 500) begin
      tick();
      k++;
    end
    if (k >= 500) begin
      n_cmp++; n_bad++;
      $display("FAIL midrst_timeout: got aw=%0d w=%0d required aw=2 w>=20", aw_cnt, w_cnt);
    end
    rst_cycles = 1;
    tick();
    tick();
    chk("midrst_awvalid", m_awvalid, 0);
    chk("midrst_wvalid", m_wvalid, 0);
    chk("midrst_wlast", m_wlast, 0);
    chk("midrst_done", done, 1);
    chk("midrst_s_ready", s_ready, 0);
    tick();
    start_job(32'h8000, 16, 0, 0, 0);
    wait_done(1000, "after_rst");
    check_job(1, 16, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
